// File: rtl/ir_sense_sched.sv
// ir_sense_sched: IR emitter duty-cycling, receiver sampling, guardrail flags
// and centre-line crossing counter for a move sequencer.
// Optional build macro: CNTR_FILTER_EN. When defined, a crossing needs two
// consecutive low centre samples after a high one, which rejects
// single-sample glitches.
module ir_sense_sched #(
  parameter int PERIOD    = 1000,
  parameter int ON_CYCLES = 200,
  parameter int SETTLE    = 150
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lftIR_n,
  input  logic       cntrIR_n,
  input  logic       rghtIR_n,
  input  logic       move_start,
  input  logic [3:0] num_lines,
  input  logic       move_abort,
  output logic       IR_en,
  output logic       busy,
  output logic       lft_rail,
  output logic       rght_rail,
  output logic       cntr_pulse,
  output logic [3:0] line_cnt,
  output logic       move_done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [15:0] PHASE_MAX = 16'(PERIOD - 1);
  localparam logic [15:0] ON_LIM    = 16'(ON_CYCLES);
  localparam logic [15:0] SAMPLE_PH = 16'(SETTLE);

`ifdef CNTR_FILTER_EN
  localparam int HIST_W = 2;
`else
  localparam int HIST_W = 1;
`endif

  // Raw receivers packed as {left, centre, right}; all active low.
  logic [2:0] raw_n;
  logic [2:0] sync_n;
  assign raw_n = {lftIR_n, cntrIR_n, rghtIR_n};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic s1_reg;
      logic s2_reg;
      // Two-flop synchroniser; idles at 1 (receiver not seeing anything).
      always_ff @(posedge clk) begin
        if (rst) begin
          s1_reg <= 1'b1;
          s2_reg <= 1'b1;
        end else begin
          s1_reg <= raw_n[gi];
          s2_reg <= s1_reg;
        end
      end
      assign sync_n[gi] = s2_reg;
    end
  endgenerate

  logic sync_lft_n;
  logic sync_cntr_n;
  logic sync_rght_n;
  assign sync_lft_n  = sync_n[2];
  assign sync_cntr_n = sync_n[1];
  assign sync_rght_n = sync_n[0];

  logic [0:0]        state_reg,     state_next;
  logic [15:0]       phase_reg,     phase_next;
  logic [3:0]        target_reg,    target_next;
  logic [3:0]        line_cnt_reg,  line_cnt_next;
  logic [HIST_W-1:0] prev_cntr_reg, prev_cntr_next;
  logic              lft_rail_reg,  lft_rail_next;
  logic              rght_rail_reg, rght_rail_next;
  logic              pulse_reg,     pulse_next;
  logic              done_reg,      done_next;

  logic       sample_evt;
  logic       crossing;
  logic [3:0] cnt_inc;

  assign sample_evt = (phase_reg == SAMPLE_PH);
  assign cnt_inc    = line_cnt_reg + 4'd1;

`ifdef CNTR_FILTER_EN
  // prev_cntr_reg[0] is the most recent sample, [1] the one before it.
  assign crossing = !sync_cntr_n && !prev_cntr_reg[0] && prev_cntr_reg[1];
`else
  assign crossing = !sync_cntr_n && prev_cntr_reg[0];
`endif

  // Next-state logic for the move FSM, phase counter and sampled outputs.
  always_comb begin
    state_next     = state_reg;
    phase_next     = phase_reg;
    target_next    = target_reg;
    line_cnt_next  = line_cnt_reg;
    prev_cntr_next = prev_cntr_reg;
    lft_rail_next  = lft_rail_reg;
    rght_rail_next = rght_rail_reg;
    pulse_next     = 1'b0;
    done_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        phase_next     = 16'd0;
        lft_rail_next  = 1'b0;
        rght_rail_next = 1'b0;
        if (move_start) begin
          if (num_lines != 4'd0) begin
            state_next     = RUN;
            target_next    = num_lines;
            line_cnt_next  = 4'd0;
            prev_cntr_next = '1;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      RUN: begin
        phase_next = (phase_reg == PHASE_MAX) ? 16'd0 : phase_reg + 16'd1;
        // Leaving RUN is delayed one cycle after move_done so that busy
        // overlaps the done pulse; abort wins over any sample this cycle.
        if (move_abort || done_reg) begin
          state_next     = IDLE;
          phase_next     = 16'd0;
          lft_rail_next  = 1'b0;
          rght_rail_next = 1'b0;
        end else if (sample_evt) begin
          lft_rail_next  = !sync_lft_n;
          rght_rail_next = !sync_rght_n;
`ifdef CNTR_FILTER_EN
          prev_cntr_next = {prev_cntr_reg[0], sync_cntr_n};
`else
          prev_cntr_next = sync_cntr_n;
`endif
          if (crossing && (line_cnt_reg != 4'hF)) begin
            pulse_next    = 1'b1;
            line_cnt_next = cnt_inc;
            done_next     = (cnt_inc == target_reg);
          end
        end
      end
      default: begin
        state_next = IDLE;
        phase_next = 16'd0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      phase_reg     <= 16'd0;
      target_reg    <= 4'd0;
      line_cnt_reg  <= 4'd0;
      prev_cntr_reg <= '1;
      lft_rail_reg  <= 1'b0;
      rght_rail_reg <= 1'b0;
      pulse_reg     <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      phase_reg     <= phase_next;
      target_reg    <= target_next;
      line_cnt_reg  <= line_cnt_next;
      prev_cntr_reg <= prev_cntr_next;
      lft_rail_reg  <= lft_rail_next;
      rght_rail_reg <= rght_rail_next;
      pulse_reg     <= pulse_next;
      done_reg      <= done_next;
    end
  end

  assign busy       = (state_reg == RUN);
  assign IR_en      = (state_reg == RUN) && (phase_reg < ON_LIM);
  assign lft_rail   = lft_rail_reg;
  assign rght_rail  = rght_rail_reg;
  assign cntr_pulse = pulse_reg;
  assign line_cnt   = line_cnt_reg;
  assign move_done  = done_reg;

endmodule

// File: tb/tb_ir_sense_sched.sv
// Testbench for ir_sense_sched with default parameters (1000/200/150).
// Table-driven guardrail/crossing vectors inside one long move, plus
// hand-written sequences for reset, basic move, abort race and zero target.
module tb_ir_sense_sched;

  localparam int PERIOD = 1000;
  localparam int SETTLE = 150;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lftIR_n = 1'b1;
  logic       cntrIR_n = 1'b1;
  logic       rghtIR_n = 1'b1;
  logic       move_start = 1'b0;
  logic [3:0] num_lines = 4'd0;
  logic       move_abort = 1'b0;
  logic       IR_en;
  logic       busy;
  logic       lft_rail;
  logic       rght_rail;
  logic       cntr_pulse;
  logic [3:0] line_cnt;
  logic       move_done;

  ir_sense_sched dut (
    .clk        (clk),
    .rst        (rst),
    .lftIR_n    (lftIR_n),
    .cntrIR_n   (cntrIR_n),
    .rghtIR_n   (rghtIR_n),
    .move_start (move_start),
    .num_lines  (num_lines),
    .move_abort (move_abort),
    .IR_en      (IR_en),
    .busy       (busy),
    .lft_rail   (lft_rail),
    .rght_rail  (rght_rail),
    .cntr_pulse (cntr_pulse),
    .line_cnt   (line_cnt),
    .move_done  (move_done)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       lft_n;
    logic       cntr_n;
    logic       rght_n;
    logic       exp_lft;
    logic       exp_rght;
    logic       exp_pulse;
    logic [3:0] exp_cnt;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(input logic l, input logic c, input logic r,
                              input logic el, input logic er, input logic ep,
                              input logic [3:0] ec);
    vec_t v;
    v.lft_n = l; v.cntr_n = c; v.rght_n = r;
    v.exp_lft = el; v.exp_rght = er; v.exp_pulse = ep; v.exp_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Ends at #1 into the first RUN cycle (phase 0).
  task automatic start_move(input logic [3:0] n);
    num_lines  = n;
    move_start = 1'b1;
    step(1);
    move_start = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int ir_hi;
    int pulses;
    int p_cyc [2];
    int done_cyc;
    int fell;
    int exp_p0;
    int exp_p1;
    int low1_s, low1_e, low2_s, low2_e;
    int wait_n;
    logic ir_seen;

    // ---- expected vector table ----
    tbl[0]  = mk(1, 1, 1, 0, 0, 0, 4'd0);
    tbl[1]  = mk(0, 1, 1, 1, 0, 0, 4'd0);
    tbl[2]  = mk(1, 1, 1, 0, 0, 0, 4'd0);
    tbl[3]  = mk(1, 1, 0, 0, 1, 0, 4'd0);
`ifdef CNTR_FILTER_EN
    tbl[4]  = mk(1, 0, 1, 0, 0, 0, 4'd0);
    tbl[5]  = mk(1, 1, 1, 0, 0, 0, 4'd0);
    tbl[6]  = mk(1, 0, 1, 0, 0, 0, 4'd0);
    tbl[7]  = mk(1, 0, 1, 0, 0, 1, 4'd1);
    tbl[8]  = mk(1, 0, 1, 0, 0, 0, 4'd1);
    tbl[9]  = mk(1, 1, 1, 0, 0, 0, 4'd1);
    tbl[10] = mk(0, 0, 0, 1, 1, 0, 4'd1);
    tbl[11] = mk(1, 1, 1, 0, 0, 0, 4'd1);
    tbl[12] = mk(0, 1, 1, 1, 0, 0, 4'd1);
    low1_s = 100; low1_e = 2600; low2_s = 4600; low2_e = 7100;
    exp_p0 = 1151; exp_p1 = 6151;
`else
    tbl[4]  = mk(1, 0, 1, 0, 0, 1, 4'd1);
    tbl[5]  = mk(1, 1, 1, 0, 0, 0, 4'd1);
    tbl[6]  = mk(1, 0, 1, 0, 0, 1, 4'd2);
    tbl[7]  = mk(1, 0, 1, 0, 0, 0, 4'd2);
    tbl[8]  = mk(1, 0, 1, 0, 0, 0, 4'd2);
    tbl[9]  = mk(1, 1, 1, 0, 0, 0, 4'd2);
    tbl[10] = mk(0, 0, 0, 1, 1, 1, 4'd3);
    tbl[11] = mk(1, 1, 1, 0, 0, 0, 4'd3);
    tbl[12] = mk(0, 1, 1, 1, 0, 0, 4'd3);
    low1_s = 100; low1_e = 1600; low2_s = 3600; low2_e = 5100;
    exp_p0 = 151; exp_p1 = 4151;
`endif

    // ---- reset ----
    rst = 1'b1;
    step(3);
    chk("rst_IR_en", IR_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lft_rail", lft_rail, 0);
    chk("rst_rght_rail", rght_rail, 0);
    chk("rst_cntr_pulse", cntr_pulse, 0);
    chk("rst_line_cnt", line_cnt, 0);
    chk("rst_move_done", move_done, 0);
    rst = 1'b0;
    ir_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      ir_seen = ir_seen | IR_en | busy;
    end
    chk("idle_no_IR_en", ir_seen, 0);
    $display("reset: done");

    // ---- basic move, num_lines=2 ----
    start_move(4'd2);
    ir_hi = 0; pulses = 0; p_cyc[0] = -1; p_cyc[1] = -1; done_cyc = -1; fell = -1;
    for (int k = 0; k < 9000; k++) begin
      cntrIR_n = !((k >= low1_s && k < low1_e) || (k >= low2_s && k < low2_e));
      @(negedge clk);
      if (k < PERIOD && IR_en) ir_hi++;
      if (k == 0) begin
        chk("move_busy_T1", busy, 1);
        chk("move_IR_en_T1", IR_en, 1);
      end
      if (cntr_pulse) begin
        if (pulses < 2) p_cyc[pulses] = k;
        chk("move_line_cnt_at_pulse", line_cnt, pulses + 1);
        pulses++;
      end
      if (move_done && done_cyc < 0) done_cyc = k;
      if (!busy) begin
        fell = k;
        chk("move_IR_en_after_done", IR_en, 0);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    cntrIR_n = 1'b1;
    chk("move_IR_en_high_cycles", ir_hi, 200);
    chk("move_pulse_count", pulses, 2);
    chk("move_pulse0_cycle", p_cyc[0], exp_p0);
    chk("move_pulse1_cycle", p_cyc[1], exp_p1);
    chk("move_done_cycle", done_cyc, exp_p1);
    chk("move_busy_fall_cycle", fell, exp_p1 + 1);
    chk("move_final_line_cnt", line_cnt, 2);
    $display("basic move: pulses=%0d at %0d/%0d done=%0d busy_fall=%0d",
             pulses, p_cyc[0], p_cyc[1], done_cyc, fell);

    // ---- table-driven vectors in one long move ----
    step(3);
    start_move(4'd15);
    for (int i = 0; i < 13; i++) begin
      lftIR_n  = tbl[i].lft_n;
      cntrIR_n = tbl[i].cntr_n;
      rghtIR_n = tbl[i].rght_n;
      wait_n = (i == 0) ? SETTLE + 1 : PERIOD;
      if (i == 6) begin
        // move_start while running must be ignored
        num_lines  = 4'd1;
        move_start = 1'b1;
        step(1);
        move_start = 1'b0;
        wait_n = wait_n - 1;
      end
      step(wait_n);
      chk($sformatf("vec%0d_lft_rail", i), lft_rail, tbl[i].exp_lft);
      chk($sformatf("vec%0d_rght_rail", i), rght_rail, tbl[i].exp_rght);
      chk($sformatf("vec%0d_cntr_pulse", i), cntr_pulse, tbl[i].exp_pulse);
      chk($sformatf("vec%0d_line_cnt", i), line_cnt, tbl[i].exp_cnt);
      chk($sformatf("vec%0d_busy", i), busy, 1);
      $display("vec%0d: in l/c/r=%b%b%b rails=%b%b pulse=%b cnt=%0d",
               i, tbl[i].lft_n, tbl[i].cntr_n, tbl[i].rght_n,
               lft_rail, rght_rail, cntr_pulse, line_cnt);
    end
    // plain abort with a rail set
    move_abort = 1'b1;
    step(1);
    move_abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_IR_en", IR_en, 0);
    chk("abort_lft_rail", lft_rail, 0);
    chk("abort_line_cnt_hold", line_cnt, tbl[12].exp_cnt);
    chk("abort_move_done", move_done, 0);
    lftIR_n = 1'b1;
    $display("abort: busy=%b line_cnt=%0d", busy, line_cnt);

    // ---- abort racing a qualifying sample, target 1 ----
    cntrIR_n = 1'b0;
    step(3);
    start_move(4'd1);
    step(SETTLE);
    chk("race_pre_pulse", cntr_pulse, 0);
    move_abort = 1'b1;
    step(1);
    move_abort = 1'b0;
    chk("race_cntr_pulse", cntr_pulse, 0);
    chk("race_line_cnt", line_cnt, 0);
    chk("race_move_done", move_done, 0);
    chk("race_busy", busy, 0);
    chk("race_IR_en", IR_en, 0);
    step(1);
    chk("race_move_done_late", move_done, 0);
    chk("race_cntr_pulse_late", cntr_pulse, 0);
    cntrIR_n = 1'b1;
    $display("abort race: pulse=%b cnt=%0d done=%b busy=%b",
             cntr_pulse, line_cnt, move_done, busy);

    // ---- zero target ----
    step(3);
    num_lines  = 4'd0;
    move_start = 1'b1;
    step(1);
    move_start = 1'b0;
    chk("zero_move_done", move_done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_IR_en", IR_en, 0);
    step(1);
    chk("zero_move_done_once", move_done, 0);
    chk("zero_busy_after", busy, 0);
    $display("zero target: done pulse seen, busy=%b", busy);

    // ---- reset mid-move ----
    step(2);
    lftIR_n = 1'b0;
    start_move(4'd5);
    step(SETTLE + 1);
    chk("midrst_rail_before", lft_rail, 1);
    rst = 1'b1;
    step(1);
    chk("midrst_busy", busy, 0);
    chk("midrst_IR_en", IR_en, 0);
    chk("midrst_lft_rail", lft_rail, 0);
    chk("midrst_line_cnt", line_cnt, 0);
    rst = 1'b0;
    lftIR_n = 1'b1;
    step(2);
    chk("midrst_stays_idle", busy, 0);
    $display("mid-move reset: busy=%b IR_en=%b", busy, IR_en);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ir_sense_sched.md
# ir_sense_sched

Duty-cycles the Knight's IR emitters, samples the left, centre and right IR receivers once per emitter pulse, and converts them into clean guardrail flags and centre-line crossing events. It counts centre-line crossings against a target supplied by the move controller and signals move completion. It sits between the motion/move sequencer and the IR sensor pins (`IR_en`, `lftIR_n`, `cntrIR_n`, `rghtIR_n`).

## Interface
- `PERIOD`, default 1000: clocks per emitter cycle; legal range 4..65535.
- `ON_CYCLES`, default 200: clocks `IR_en` is held high per cycle; legal range 2..PERIOD-1.
- `SETTLE`, default 150: phase at which the receivers are sampled; legal range 1..ON_CYCLES-1.

- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: synchronous, active-high reset.
- `lftIR_n` in 1: raw left IR receiver, active low, asynchronous.
- `cntrIR_n` in 1: raw centre IR receiver, active low, asynchronous.
- `rghtIR_n` in 1: raw right IR receiver, active low, asynchronous.
- `move_start` in 1: one-cycle request to begin counting lines.
- `num_lines` in 4: target crossing count. Captured on an accepted `move_start`.
- `move_abort` in 1: terminates a move without `move_done`.
- `IR_en` out 1: emitter enable.
- `busy` out 1: high while in RUN.
- `lft_rail` out 1: left guardrail seen, as of the last sample.
- `rght_rail` out 1: right guardrail seen, as of the last sample.
- `cntr_pulse` out 1: one-cycle pulse for each qualified line crossing.
- `line_cnt` out 4: crossings counted in the current move.
- `move_done` out 1: one-cycle pulse when `line_cnt` reaches the target.

## Operation
- Input synchronisation: each raw IR input passes through a 2-flop synchroniser. The synchroniser flops reset to 1.
- Move FSM, IDLE/RUN:
  - IDLE, `move_start` with `num_lines`≠0: capture `num_lines`, clear `line_cnt`, clear the phase counter, set `prev_cntr`=1, go to RUN.
  - IDLE, `move_start` with `num_lines`=0: pulse `move_done` in the next cycle; remain in IDLE.
  - RUN, `move_start`: ignored.
  - RUN, `move_abort`: go to IDLE. `line_cnt` holds its value; the rail flags are cleared.
  - RUN, final crossing: `move_done` pulses; go to IDLE.
  - Abort has priority over a simultaneous crossing: no `cntr_pulse`, no increment, no `move_done`.
- Phase counter: 16 bits, counts 0..PERIOD-1 and wraps, only while in RUN. It is held at 0 in IDLE.
- `IR_en` is 1 iff the FSM is in RUN and phase < ON_CYCLES.
- Sample event occurs when phase == SETTLE. At that clock edge:
  - `lft_rail` and `rght_rail` load the inverted synchronised receiver values.
  - `prev_cntr` loads the synchronised `cntrIR_n`.
- Crossing qualification without the filter: synchronised `cntrIR_n`=0 with `prev_cntr`=1.
- A qualified crossing registers `cntr_pulse`=1 and `line_cnt`+1 at the sample edge.
- `move_done` registers at the same edge when the new count equals the target.
- `line_cnt` saturates at 15; it cannot exceed the target.
- In IDLE, `lft_rail`, `rght_rail` and `cntr_pulse` are 0.

## Timing
- Reset values: `IR_en`=0, `busy`=0, `lft_rail`=0, `rght_rail`=0, `cntr_pulse`=0, `line_cnt`=0, `move_done`=0. The FSM resets to IDLE.
- Accepting a move: `move_start` is sampled in cycle T. Then `busy`=1 and `IR_en`=1 from T+1, with phase=0 at T+1.
- Sample cycles: the first sample edge ends cycle T+1+SETTLE. Subsequent samples occur every PERIOD cycles.
- Outputs change in the cycle after the sample edge's cycle: rails, `cntr_pulse`, `line_cnt` and `move_done`.
- Returning to IDLE: `busy` and `IR_en` drop in the cycle after `move_done` is high.
- Abort: `move_abort` in cycle A makes `busy`=0 and `IR_en`=0 from A+1.
- Input latency: a raw input change is visible to sampling 2 cycles later.
- `rst` asserted mid-move returns every state and output to its reset value at the next edge.

## Configuration
- `CNTR_FILTER_EN` defined: a crossing requires two consecutive low samples after a high sample. `cntr_pulse` fires on the second low sample, and a single-sample low glitch is ignored. `prev_cntr` is extended to a 2-sample history, initialised to 1,1.
- `CNTR_FILTER_EN` undefined: one high→low sample transition counts, as described under Operation.

## Test plan
- Reset: hold `rst` for 3 cycles -> all outputs 0; `IR_en` stays 0 with no move pending.
- Basic move: `num_lines`=2; drive `cntrIR_n` low for 1.5 PERIOD, twice, separated by 2 PERIOD high. Required response:
  - `IR_en` high 200/1000 cycles.
  - `cntr_pulse` ×2.
  - `line_cnt` 1 then 2.
  - `move_done` on the second pulse.
  - `busy` drops one cycle later.
- Guardrails: during RUN hold `lftIR_n`=0 -> `lft_rail`=1 after the next sample, and `rght_rail`=0. Release `lftIR_n` -> `lft_rail`=0 after the following sample.
- Zero target: `move_start` with `num_lines`=0 -> `move_done` for exactly 1 cycle; `busy` and `IR_en` stay 0.
- Abort race: arrange `move_abort` in the same cycle as a qualifying sample -> no `cntr_pulse`, `line_cnt` unchanged, no `move_done`, `busy`=0 next cycle.
- Filter: drive a `cntrIR_n` low pulse covering exactly one sample -> one count without `CNTR_FILTER_EN`, zero counts with it. A low pulse covering two samples counts 1 with the filter enabled.
